// File: rtl/td4_program_loader.sv
// TD4 instruction-side loader: 16-entry program memory filled over a valid/ready
// byte stream, then read by the CPU program counter while the CPU is released.
module td4_program_loader #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 8,
  parameter bit          CLEAR_ON_LOAD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   instr,
  output logic                cpu_run,
  output logic                load_done,
  output logic [ADDR_W:0]     load_count,
  output logic [7:0]          checksum
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [CNT_W-1:0]  load_count_nxt;
  logic [7:0]        checksum_nxt;
  logic              load_done_nxt;
  logic              in_ready_nxt;
  logic              cpu_run_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              accept;
  logic              clear_mem;

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    wptr_nxt       = wptr;
    load_count_nxt = load_count;
    checksum_nxt   = checksum;
    load_done_nxt  = load_done;
    accept         = 1'b0;
    clear_mem      = 1'b0;

    case (state)
      S_IDLE: begin
        if (load_en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        accept = in_valid & in_ready;
        if (accept) begin
          wptr_nxt       = wptr + ADDR_W'(1);
          load_count_nxt = load_count + CNT_W'(1);
          checksum_nxt   = checksum + 8'(in_data);
        end
        // The 16th byte completes the load even if load_en drops with it
        if (accept && (load_count == CNT_W'(DEPTH - 1))) begin
          state_nxt     = S_RUN;
          load_done_nxt = 1'b1;
        end else if (!load_en) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (load_en) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase

    if ((state_nxt == S_LOAD) && (state != S_LOAD)) begin
      wptr_nxt       = '0;
      load_count_nxt = '0;
      checksum_nxt   = '0;
      load_done_nxt  = 1'b0;
      clear_mem      = CLEAR_ON_LOAD;
    end

    in_ready_nxt = (state_nxt == S_LOAD);
    cpu_run_nxt  = (state_nxt == S_RUN);
    // Only fetch while staying in RUN so instr reads zero for all of LOAD
    instr_nxt    = ((state == S_RUN) && (state_nxt == S_RUN)) ? mem[pc] : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wptr       <= '0;
      load_count <= '0;
      checksum   <= '0;
      load_done  <= 1'b0;
      in_ready   <= 1'b0;
      cpu_run    <= 1'b0;
      instr      <= '0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      load_count <= load_count_nxt;
      checksum   <= checksum_nxt;
      load_done  <= load_done_nxt;
      in_ready   <= in_ready_nxt;
      cpu_run    <= cpu_run_nxt;
      instr      <= instr_nxt;
    end
  end

  // Program memory
  always_ff @(posedge clk) begin
    if (rst || clear_mem) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_td4_program_loader.sv
// Directed plus randomized bench for td4_program_loader against a byte-array model.
module tb_td4_program_loader;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       cpu_run;
  logic       load_done;
  logic [4:0] load_count;
  logic [7:0] checksum;

  td4_program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pc         (pc),
    .instr      (instr),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_count (load_count),
    .checksum   (checksum)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [16];
  int         ref_count;
  int         ref_sum;
  logic [7:0] data_q [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_count = 0;
    ref_sum   = 0;
  endtask

  // Enter LOAD, stream n bytes from data_q (mode 0 continuous, 1 toggled, 2 random), end in RUN
  task automatic load_seq(input int n, input int mode);
    int   cyc;
    logic v;
    logic tog;
    load_en  = 1'b1;
    in_valid = 1'b0;
    tick();
    model_clear();
    chk("entry_in_ready", 32'(in_ready), 32'd1);
    chk("entry_cpu_run", 32'(cpu_run), 32'd0);
    chk("entry_count", 32'(load_count), 32'd0);
    chk("entry_checksum", 32'(checksum), 32'd0);
    chk("entry_done", 32'(load_done), 32'd0);
    chk("entry_instr", 32'(instr), 32'd0);
    cyc = 0;
    tog = 1'b0;
    while (ref_count < n && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? data_q[ref_count] : 8'($urandom);
      if (v && ref_count == n - 1) load_en = 1'b0;
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_instr", 32'(instr), 32'd0);
      chk("load_cpu_run", 32'(cpu_run), 32'd0);
      tick();
      cyc++;
      if (v) begin
        ref_mem[ref_count] = data_q[ref_count];
        ref_sum   = (ref_sum + int'(data_q[ref_count])) % 256;
        ref_count++;
      end
      chk("load_count_step", 32'(load_count), 32'(ref_count));
    end
    if (cyc >= 200) begin
      checks++;
      errors++;
      $error("FAIL load_timeout observed=%0d bytes expected=%0d bytes", ref_count, n);
    end
    // A byte offered after the load ends must be ignored
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    in_valid = 1'b0;
    chk("run_cpu_run", 32'(cpu_run), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    chk("run_done", 32'(load_done), 32'(ref_count == 16));
    chk("run_count", 32'(load_count), 32'(ref_count));
    chk("run_checksum", 32'(checksum), 32'(ref_sum));
  endtask

  task automatic read_pc(input int p);
    pc = 4'(p);
    tick();
    chk($sformatf("instr_pc%0d", p), 32'(instr), 32'(ref_mem[p]));
  endtask

  initial begin
    rst      = 1'b1;
    load_en  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pc       = 4'h0;
    model_clear();

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_instr", 32'(instr), 32'd0);
      chk("idle_cpu_run", 32'(cpu_run), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_count", 32'(load_count), 32'd0);
    end

    // Full load 0x10..0x1F and run
    for (int i = 0; i < 16; i++) data_q[i] = 8'(8'h10 + i);
    load_seq(16, 0);
    chk("full_checksum_const", 32'(checksum), 32'h78);
    chk("full_count_const", 32'(load_count), 32'd16);
    read_pc(5);
    chk("pc5_const", 32'(instr), 32'h15);
    read_pc(15);
    chk("pc15_const", 32'(instr), 32'h1F);
    for (int i = 0; i < 16; i++) read_pc(i);

    // Reload from RUN with all 0xFF
    for (int i = 0; i < 16; i++) data_q[i] = 8'hFF;
    load_seq(16, 0);
    chk("ff_checksum_const", 32'(checksum), 32'hF0);
    read_pc(9);

    // Backpressure gaps
    for (int i = 0; i < 16; i++) data_q[i] = 8'(8'h10 + i);
    load_seq(16, 1);
    chk("gap_checksum_const", 32'(checksum), 32'h78);
    for (int i = 0; i < 16; i++) read_pc(i);

    // Aborted load of three bytes
    data_q[0] = 8'hB3;
    data_q[1] = 8'h01;
    data_q[2] = 8'hF0;
    load_seq(3, 0);
    chk("abort_checksum_const", 32'(checksum), 32'hA4);
    chk("abort_done_const", 32'(load_done), 32'd0);
    for (int i = 0; i < 4; i++) read_pc(i);
    chk("abort_pc3_const", 32'(instr), 32'h00);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) data_q[i] = 8'($urandom);
      load_seq(int'($urandom_range(1, 16)), 2);
      for (int i = 0; i < 16; i++) read_pc(int'($urandom_range(0, 15)));
    end

    // Reset mid-load after 7 bytes
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      tick();
    end
    chk("midload_count", 32'(load_count), 32'd7);
    in_valid = 1'b0;
    load_en  = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    tick();
    chk("rst_idle_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) data_q[i] = 8'(i);
    load_seq(16, 0);
    read_pc(7);
    chk("post_rst_pc7_const", 32'(instr), 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
